pipelined_cla_addsub: RTL

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead blocks. Each block produces block propagate/generate, and a second lookahead level combines them within each pipeline stage. Carries are registered between stages, so wide operands run at a high clock rate. The block sits between the operand-fetch logic and the result writeback path, with valid/ready handshakes on both sides.

---
 rtl/pipelined_cla_addsub_if.sv | 28 ++
 rtl/pipelined_cla_addsub.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for pipelined_cla_addsub.
// The master side feeds operands and takes results; the adder is the slave.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined two-level carry-lookahead adder/subtractor with a global-stall handshake.
// Stage k adds operand slice k; carries, skewed operands and partial sums move stage to stage.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 16,  // multiple of 4
    parameter int STAGES = 2    // must divide WIDTH/4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_cla_addsub_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NB   = SEG / 4;
    localparam int L    = STAGES - 1;
    localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

    // Lookahead carries c[0..4] of a 4-bit group, all as sum-of-products of (p, g, c).
    // NOTE: blocking assignments are correct here: function locals are combinational temporaries.
    function automatic logic [4:0] look4(input logic [3:0] p, input logic [3:0] g, input logic c);
        logic [4:0] cy;
        logic       t;
        for (int j = 0; j <= 4; j++) begin
            t = c;
            for (int i = 0; i < j; i++) t = t & p[i];
            cy[j] = t;
            for (int i = 0; i < j; i++) begin
                t = g[i];
                for (int m = i + 1; m < j; m++) t = t & p[m];
                cy[j] = cy[j] | t;
            end
        end
        return cy;
    endfunction

    // One SEG-bit slice: block P/G from each 4-bit group, then a second lookahead level.
    function automatic logic [SEG:0] add_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                             input logic c);
        logic [NB-1:0]  bp;
        logic [NB-1:0]  bg;
        logic [NB:0]    cb;
        logic [4:0]     cw;
        logic [SEG-1:0] s;
        logic           t;
        for (int j = 0; j < NB; j++) begin
            cw    = look4(x[4*j +: 4] | y[4*j +: 4], x[4*j +: 4] & y[4*j +: 4], 1'b0);
            bp[j] = &(x[4*j +: 4] | y[4*j +: 4]);
            bg[j] = cw[4];
        end
        for (int j = 0; j <= NB; j++) begin
            t = c;
            for (int i = 0; i < j; i++) t = t & bp[i];
            cb[j] = t;
            for (int i = 0; i < j; i++) begin
                t = bg[i];
                for (int m = i + 1; m < j; m++) t = t & bp[m];
                cb[j] = cb[j] | t;
            end
        end
        for (int j = 0; j < NB; j++) begin
            cw           = look4(x[4*j +: 4] | y[4*j +: 4], x[4*j +: 4] & y[4*j +: 4], cb[j]);
            s[4*j +: 4]  = x[4*j +: 4] ^ y[4*j +: 4] ^ cw[3:0];
        end
        return {cb[NB], s};
    endfunction

    logic             advance;
    logic             v_q [NMID];
    logic             c_q [NMID];
    logic [WIDTH-1:0] a_q [NMID];
    logic [WIDTH-1:0] b_q [NMID];
    logic [WIDTH-1:0] s_q [NMID];

    logic             st_v [STAGES];
    logic             st_c [STAGES];
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             nx_c [STAGES];
    logic [WIDTH-1:0] nx_s [STAGES];
    logic             msb_cin;

    assign advance      = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = advance;

    // NOTE: every array element is assigned on every pass, so no latch can be inferred.
    always_comb begin
        st_v[0] = bus.in_valid;
        st_a[0] = bus.a;
        st_b[0] = bus.sub ? ~bus.b : bus.b;
        st_c[0] = bus.sub | bus.cin;
        st_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            st_v[k] = v_q[k-1];
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_c[k] = c_q[k-1];
            st_s[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            nx_s[k] = st_s[k];
            {nx_c[k], nx_s[k][k*SEG +: SEG]} =
                add_seg(st_a[k][k*SEG +: SEG], st_b[k][k*SEG +: SEG], st_c[k]);
        end
    end

    // Carry into the MSB recovered from the MSB's own sum bit.
    assign msb_cin = st_a[L][WIDTH-1] ^ st_b[L][WIDTH-1] ^ nx_s[L][WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NMID; k++) v_q[k] <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.cout      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) v_q[k] <= st_v[k];
            bus.out_valid <= st_v[L];
            bus.result    <= nx_s[L];
            bus.cout      <= nx_c[L];
            bus.overflow  <= msb_cin ^ nx_c[L];
            bus.zero      <= ~|nx_s[L];
        end
    end

    // NOTE: inter-stage data registers carry no reset; the stage valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= st_a[k];
                b_q[k] <= st_b[k];
                c_q[k] <= nx_c[k];
                s_q[k] <= nx_s[k];
            end
        end
    end
endmodule
